// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Words are assembled big-endian: the byte at the word address lands in bits 31:24.
package instr_fetch_queue_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_PUSH = 2'd2
  } fetch_state_e;

  // Older bytes move toward the MSBs as each new byte arrives.
  function automatic logic [23:0] shift_in_byte(input logic [23:0] acc, input logic [7:0] b);
    return {acc[15:0], b};
  endfunction

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Small synchronous prefetch FIFO holding {instruction, pc} entries.
// Flush has priority over push and pop; pop of an empty FIFO is ignored.
module fetch_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int WIDTH = INSTR_W + 8,
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_push_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_head_data,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_push = i_push & ~w_full & ~i_flush;
  assign w_do_pop  = i_pop & ~w_empty & ~i_flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_empty     = w_empty;
  assign o_count     = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: reads four bytes per instruction from byte-wide memory, assembles
// a big-endian word and queues it with its pc; redirect flushes and restarts fetch.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  output logic                         o_mem_rd_en,
  output logic [ADDR_W-1:0]            o_mem_addr,
  input  logic [7:0]                   i_mem_rd_data,
  input  logic                         i_redirect,
  input  logic [ADDR_W-1:0]            i_redirect_pc,
  output logic                         o_instr_valid,
  input  logic                         i_instr_ready,
  output logic [INSTR_W-1:0]           o_instr,
  output logic [ADDR_W-1:0]            o_instr_pc,
  output logic [OPCODE_W-1:0]          o_opcode,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  fetch_state_e       r_state;
  fetch_state_e       w_state_next;
  logic [1:0]         r_bcnt;
  logic [1:0]         w_bcnt_next;
  logic [23:0]        r_asm;
  logic [23:0]        w_asm_next;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  w_fetch_pc_next;
  logic               w_rd_en;
  logic               w_push;
  logic               w_pop;
  logic               w_valid;
  logic               w_fifo_empty;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W:0]     w_count_after_push;
  logic [ENTRY_W-1:0] w_push_entry;
  logic [ENTRY_W-1:0] w_head_entry;

  assign w_valid            = ~w_fifo_empty;
  assign w_pop              = w_valid & i_instr_ready;
  assign w_push             = (r_state == ST_PUSH) & ~i_redirect;
  assign w_push_entry       = {r_asm, i_mem_rd_data, r_fetch_pc};
  assign w_count_after_push = {1'b0, w_count} + (CNT_W+1)'(1) - (CNT_W+1)'(w_pop);

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_redirect),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head_data (w_head_entry),
    .o_empty     (w_fifo_empty),
    .o_count     (w_count)
  );

  always_comb begin
    w_state_next    = r_state;
    w_bcnt_next     = r_bcnt;
    w_asm_next      = r_asm;
    w_fetch_pc_next = r_fetch_pc;
    w_rd_en         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_count < CNT_W'(DEPTH)) w_state_next = ST_REQ;
      end
      ST_REQ: begin
        w_rd_en     = 1'b1;
        w_bcnt_next = r_bcnt + 2'd1;
        // Data for the previous issue arrives now; bcnt 0 has nothing returning yet.
        if (r_bcnt != 2'd0) w_asm_next = shift_in_byte(r_asm, i_mem_rd_data);
        if (r_bcnt == 2'd3) w_state_next = ST_PUSH;
      end
      ST_PUSH: begin
        w_asm_next      = '0;
        w_fetch_pc_next = r_fetch_pc + ADDR_W'(4);
        w_state_next    = (w_count_after_push < (CNT_W+1)'(DEPTH)) ? ST_REQ : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (i_redirect) begin
      w_state_next    = ST_IDLE;
      w_bcnt_next     = 2'd0;
      w_asm_next      = '0;
      w_fetch_pc_next = {i_redirect_pc[ADDR_W-1:2], 2'b00};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_bcnt     <= 2'd0;
      r_asm      <= '0;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_bcnt     <= w_bcnt_next;
      r_asm      <= w_asm_next;
      r_fetch_pc <= w_fetch_pc_next;
    end
  end

  assign o_mem_rd_en   = w_rd_en;
  assign o_mem_addr    = r_fetch_pc + ADDR_W'(r_bcnt);
  assign o_instr_valid = w_valid;
  assign o_instr       = w_valid ? w_head_entry[ENTRY_W-1 -: INSTR_W] : '0;
  assign o_instr_pc    = w_valid ? w_head_entry[ADDR_W-1:0] : '0;
  assign o_opcode      = o_instr[INSTR_W-1 -: OPCODE_W];
  assign o_count       = w_count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench: byte memory model with registered read, scoreboard of expected words.
module tb_instr_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        ready;
  logic        ready2;

  logic        rd_en, rd_en2;
  logic [7:0]  addr, addr2;
  logic [7:0]  rd_data, rd_data2;
  logic        valid, valid2;
  logic [31:0] instr, instr2;
  logic [7:0]  pc, pc2;
  logic [5:0]  opcode, opcode2;
  logic [2:0]  count, count2;

  logic [7:0]  mem [256];

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb2_q[$];

  int tests_run;
  int tests_failed;

  instr_fetch_queue #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'h00)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_mem_rd_en(rd_en), .o_mem_addr(addr), .i_mem_rd_data(rd_data),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_instr_valid(valid), .i_instr_ready(ready),
    .o_instr(instr), .o_instr_pc(pc), .o_opcode(opcode), .o_count(count)
  );

  instr_fetch_queue #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'hFC)) u_dut_fc (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_mem_rd_en(rd_en2), .o_mem_addr(addr2), .i_mem_rd_data(rd_data2),
    .i_redirect(1'b0), .i_redirect_pc(8'h00),
    .o_instr_valid(valid2), .i_instr_ready(ready2),
    .o_instr(instr2), .o_instr_pc(pc2), .o_opcode(opcode2), .o_count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en)  rd_data  <= mem[addr];
    if (rd_en2) rd_data2 <= mem[addr2];
  end

  function automatic exp_t make_exp(input logic [7:0] p);
    exp_t e;
    logic [7:0] a;
    a = p;
    e.pc = p;
    e.word[31:24] = mem[a]; a = a + 8'd1;
    e.word[23:16] = mem[a]; a = a + 8'd1;
    e.word[15:8]  = mem[a]; a = a + 8'd1;
    e.word[7:0]   = mem[a];
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = 8'h00;
    ready = 1'b0;
    ready2 = 1'b0;
    sb_q.delete();
    sb2_q.delete();
    step(2);
  endtask

  // Pops n words from the main DUT, checking each against the scoreboard head.
  task automatic drain(input int n, input int budget);
    int left;
    int cyc;
    exp_t e;
    left = n;
    cyc = 0;
    ready = 1'b1;
    while (left > 0 && cyc < budget) begin
      if (valid) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL sb_unexpected: got pc=%02h instr=%08h, scoreboard empty", pc, instr);
        end else begin
          e = sb_q.pop_front();
          if (instr !== e.word || pc !== e.pc || opcode !== e.word[31:26]) begin
            tests_failed++;
            $display("[TB] FAIL pop_word: got pc=%02h instr=%08h op=%02h, want pc=%02h instr=%08h op=%02h",
                     pc, instr, opcode, e.pc, e.word, e.word[31:26]);
          end else begin
            $display("[TB] pop pc=%02h instr=%08h op=%02h ok", pc, instr, opcode);
          end
        end
        left--;
      end
      step(1);
      cyc++;
    end
    ready = 1'b0;
    if (left > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain_timeout: %0d words missing, want 0", left);
    end
  endtask

  task automatic test_reset();
    hold_reset();
    tests_run++;
    if (valid !== 1'b0 || instr !== 32'h0 || pc !== 8'h00 || opcode !== 6'h0 ||
        rd_en !== 1'b0 || count !== 3'd0 || addr !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: valid=%b instr=%08h pc=%02h op=%02h rd_en=%b count=%0d addr=%02h, want all 0",
               valid, instr, pc, opcode, rd_en, count, addr);
    end else $display("[TB] reset outputs ok");
    rst_n = 1'b1;
    sb_q.push_back(make_exp(8'h00));
    sb_q.push_back(make_exp(8'h04));
    sb_q.push_back(make_exp(8'h08));
    step(5);
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL early_valid: valid=%b after 5 edges, want 0", valid);
    end
    step(1);
    tests_run++;
    if (valid !== 1'b1 || instr !== 32'h18000020 || pc !== 8'h00 || opcode !== 6'd6) begin
      tests_failed++;
      $display("[TB] FAIL first_word: valid=%b instr=%08h pc=%02h op=%0d, want 1 18000020 00 6",
               valid, instr, pc, opcode);
    end else $display("[TB] first word at edge 6 ok");
    drain(3, 40);
  endtask

  task automatic test_full();
    hold_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) sb_q.push_back(make_exp(8'(i * 4)));
    step(30);
    tests_run++;
    if (count !== 3'd4) begin
      tests_failed++;
      $display("[TB] FAIL full_count: count=%0d, want 4", count);
    end else $display("[TB] fifo full count=4 ok");
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (rd_en !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL full_stall: rd_en=%b while full, want 0", rd_en);
      end
      step(1);
    end
    drain(1, 5);
    begin
      int cyc;
      cyc = 0;
      while (rd_en !== 1'b1 && cyc < 10) begin
        step(1);
        cyc++;
      end
      tests_run++;
      if (rd_en !== 1'b1 || addr !== 8'h10) begin
        tests_failed++;
        $display("[TB] FAIL resume_addr: rd_en=%b addr=%02h, want 1 10", rd_en, addr);
      end else $display("[TB] fetch resumed at pc=10 ok");
    end
    drain(4, 60);
  endtask

  task automatic test_redirect();
    hold_reset();
    rst_n = 1'b1;
    step(13);
    tests_run++;
    if (count !== 3'd2 || rd_en !== 1'b1 || addr !== 8'h0A) begin
      tests_failed++;
      $display("[TB] FAIL pre_redirect: count=%0d rd_en=%b addr=%02h, want 2 1 0a", count, rd_en, addr);
    end
    redirect = 1'b1;
    redirect_pc = 8'h43;
    step(1);
    redirect = 1'b0;
    tests_run++;
    if (count !== 3'd0 || valid !== 1'b0 || instr !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL redirect_flush: count=%0d valid=%b instr=%08h, want 0 0 0", count, valid, instr);
    end else $display("[TB] redirect flush ok");
    sb_q.push_back(make_exp(8'h40));
    sb_q.push_back(make_exp(8'h44));
    drain(2, 40);
  endtask

  task automatic test_redirect_push_pop();
    hold_reset();
    rst_n = 1'b1;
    step(10);
    tests_run++;
    if (count !== 3'd1 || rd_en !== 1'b0 || valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_push: count=%0d rd_en=%b valid=%b, want 1 0 1", count, rd_en, valid);
    end
    ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 8'h80;
    step(1);
    redirect = 1'b0;
    ready = 1'b0;
    tests_run++;
    if (count !== 3'd0 || valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL redirect_push_pop: count=%0d valid=%b, want 0 0", count, valid);
    end else $display("[TB] redirect dropped push and pop ok");
    sb_q.push_back(make_exp(8'h80));
    drain(1, 30);
  endtask

  task automatic test_wrap();
    exp_t e;
    int cyc;
    hold_reset();
    rst_n = 1'b1;
    sb2_q.push_back(make_exp(8'hFC));
    sb2_q.push_back(make_exp(8'h00));
    step(4);
    tests_run++;
    if (rd_en2 !== 1'b1 || addr2 !== 8'hFF) begin
      tests_failed++;
      $display("[TB] FAIL wrap_addr_ff: rd_en=%b addr=%02h, want 1 ff", rd_en2, addr2);
    end
    step(2);
    tests_run++;
    if (rd_en2 !== 1'b1 || addr2 !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL wrap_addr_00: rd_en=%b addr=%02h, want 1 00", rd_en2, addr2);
    end else $display("[TB] mem_addr wrapped ff->00 ok");
    for (int k = 0; k < 2; k++) begin
      cyc = 0;
      while (valid2 !== 1'b1 && cyc < 20) begin
        step(1);
        cyc++;
      end
      e = sb2_q.pop_front();
      tests_run++;
      if (valid2 !== 1'b1 || instr2 !== e.word || pc2 !== e.pc) begin
        tests_failed++;
        $display("[TB] FAIL wrap_word: valid=%b pc=%02h instr=%08h, want 1 %02h %08h",
                 valid2, pc2, instr2, e.pc, e.word);
      end else $display("[TB] pop pc=%02h instr=%08h ok", pc2, instr2);
      ready2 = 1'b1;
      step(1);
      ready2 = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    hold_reset();
    rst_n = 1'b1;
    step(8);
    tests_run++;
    if (rd_en !== 1'b1 || count !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL pre_async: rd_en=%b count=%0d, want 1 1", rd_en, count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (valid !== 1'b0 || instr !== 32'h0 || pc !== 8'h00 || rd_en !== 1'b0 ||
        count !== 3'd0 || addr !== 8'h00 || opcode !== 6'h0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: valid=%b instr=%08h pc=%02h rd_en=%b count=%0d addr=%02h, want all 0",
               valid, instr, pc, rd_en, count, addr);
    end else $display("[TB] async reset cleared outputs ok");
    step(1);
    rst_n = 1'b1;
    sb_q.push_back(make_exp(8'h00));
    step(5);
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL refetch_early: valid=%b, want 0", valid);
    end
    step(1);
    tests_run++;
    if (valid !== 1'b1 || pc !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL refetch_pc: valid=%b pc=%02h, want 1 00", valid, pc);
    end
    drain(1, 3);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = 8'h00;
    ready = 1'b0;
    ready2 = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 11) & 8'hFF);
    mem[0] = 8'h18; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h20;
    step(1);
    test_reset();
    test_full();
    test_redirect();
    test_redirect_push_pop();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
